// File: rtl/vector_scale.sv
// Sequential signed fixed-point scalar x 3-vector multiply, one component per cycle through
// a single shared multiplier, with per-component saturation and a valid/ready handshake.
module vector_scale #(
  parameter int unsigned COMP_W    = 19,
  parameter int unsigned FRAC_BITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3*COMP_W-1:0]   in_vector,
  input  logic [COMP_W-1:0]     in_scalar,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [3*COMP_W-1:0]   out_vector,
  output logic                  out_sat,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned PW = 2 * COMP_W;

  localparam logic signed [PW-1:0] MaxVal = {{(COMP_W + 1){1'b0}}, {(COMP_W - 1){1'b1}}};
  localparam logic signed [PW-1:0] MinVal = {{(COMP_W + 1){1'b1}}, {(COMP_W - 1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StMulX, StMulY, StMulZ, StDone} state_e;

  state_e                state_q;
  logic [3*COMP_W-1:0]   vec_q;
  logic [COMP_W-1:0]     scalar_q;
  logic                  sat_acc_q;

  logic signed [COMP_W-1:0] comp;
  logic signed [PW-1:0]     comp_ext;
  logic signed [PW-1:0]     scalar_ext;
  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     shifted;
  logic                     sat_hi;
  logic                     sat_lo;
  logic [COMP_W-1:0]        result;

  // Component feeding the shared multiplier is selected by the current state.
  always_comb begin
    comp = '0;
    unique case (state_q)
      StMulX:  comp = vec_q[3*COMP_W-1:2*COMP_W];
      StMulY:  comp = vec_q[2*COMP_W-1:COMP_W];
      StMulZ:  comp = vec_q[COMP_W-1:0];
      default: comp = '0;
    endcase
  end

  always_comb begin
    comp_ext   = comp;
    scalar_ext = $signed(scalar_q);
    prod       = comp_ext * scalar_ext;
    shifted    = prod >>> FRAC_BITS;
    sat_hi     = shifted > MaxVal;
    sat_lo     = shifted < MinVal;
    if (sat_hi) begin
      result = MaxVal[COMP_W-1:0];
    end else if (sat_lo) begin
      result = MinVal[COMP_W-1:0];
    end else begin
      result = shifted[COMP_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      vec_q      <= '0;
      scalar_q   <= '0;
      sat_acc_q  <= 1'b0;
      out_vector <= '0;
      out_sat    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            vec_q     <= in_vector;
            scalar_q  <= in_scalar;
            sat_acc_q <= 1'b0;
            state_q   <= StMulX;
          end
        end
        StMulX: begin
          out_vector[3*COMP_W-1:2*COMP_W] <= result;
          sat_acc_q <= sat_acc_q | sat_hi | sat_lo;
          state_q   <= StMulY;
        end
        StMulY: begin
          out_vector[2*COMP_W-1:COMP_W] <= result;
          sat_acc_q <= sat_acc_q | sat_hi | sat_lo;
          state_q   <= StMulZ;
        end
        StMulZ: begin
          out_vector[COMP_W-1:0] <= result;
          sat_acc_q <= sat_acc_q | sat_hi | sat_lo;
          out_sat   <= sat_acc_q | sat_hi | sat_lo;
          state_q   <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);

endmodule

// File: tb/tb_vector_scale.sv
// Directed bench for vector_scale: scoreboard of expected results, checked with immediate
// assertions when the DUT presents out_valid.
module tb_vector_scale;

  localparam int W = 19;

  logic            clk;
  logic            rst;
  logic [3*W-1:0]  in_vector;
  logic [W-1:0]    in_scalar;
  logic            in_valid;
  logic            in_ready;
  logic [3*W-1:0]  out_vector;
  logic            out_sat;
  logic            out_valid;
  logic            out_ready;

  typedef struct packed {
    logic [3*W-1:0] vec;
    logic           sat;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  vector_scale #(.COMP_W(19), .FRAC_BITS(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_vector  (in_vector),
    .in_scalar  (in_scalar),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_vector (out_vector),
    .out_sat    (out_sat),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3*W-1:0] pack(input int x, input int y, input int z);
    logic [W-1:0] xs, ys, zs;
    xs = x[W-1:0];
    ys = y[W-1:0];
    zs = z[W-1:0];
    return {xs, ys, zs};
  endfunction

  // Reference: exact product, floor division by 1024, clamp to the 19-bit signed range.
  function automatic int ref_comp(input int a, input int s, output bit sat);
    longint p, q;
    p = longint'(a) * longint'(s);
    q = (p >= 0) ? (p / 1024) : -((-p + 1023) / 1024);
    sat = 1'b0;
    if (q > 262143) begin
      q = 262143;
      sat = 1'b1;
    end else if (q < -262144) begin
      q = -262144;
      sat = 1'b1;
    end
    return int'(q);
  endfunction

  // Present an operand at a negedge; the following posedge accepts it.
  task automatic issue(input int x, input int y, input int z, input int s,
                       input bit push, input logic [3*W-1:0] ev, input bit es);
    exp_t e;
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    in_vector = pack(x, y, z);
    in_scalar = s[W-1:0];
    in_valid  = 1'b1;
    if (push) begin
      e.vec = ev;
      e.sat = es;
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called one negedge after the accept edge; checks latency, data, hold, consume.
  task automatic collect(input string tag, input int hold);
    int   cycles;
    exp_t e;
    logic [3*W-1:0] first_vec;
    cycles = 1;
    while (!out_valid && cycles < 20) begin
      chk({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
      @(negedge clk);
      cycles++;
    end
    chk({tag, "_latency"}, 64'(cycles), 64'd4);
    if (exp_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_vec"}, 64'(out_vector), 64'(e.vec));
      chk({tag, "_sat"}, 64'(out_sat), 64'(e.sat));
    end
    chk({tag, "_no_ready_with_valid"}, 64'(in_ready), 64'd0);
    first_vec = out_vector;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_vec"}, 64'(out_vector), 64'(first_vec));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_pulse_end"}, 64'(out_valid), 64'd0);
    chk({tag, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int   xs [4];
    int   ys [4];
    int   zs [4];
    int   ss [4];
    bit   sx, sy, sz;
    int   rx, ry, rz;
    bit   seen;
    logic [3*W-1:0] held;

    rst       = 1'b1;
    in_vector = '0;
    in_scalar = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_vector", 64'(out_vector), 64'd0);
    chk("rst_out_sat", 64'(out_sat), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_out_valid", 64'(out_valid), 64'd0);
      chk("idle_in_ready", 64'(in_ready), 64'd1);
      chk("idle_vec", 64'(out_vector), 64'd0);
    end

    issue(1024, -3584, 256, 2048, 1'b1, pack(2048, -7168, 512), 1'b0);
    collect("basic", 0);

    issue(-1, 1, 0, 512, 1'b1, pack(-1, 0, 0), 1'b0);
    collect("trunc", 0);

    issue(200000, -200000, 1024, 4096, 1'b1, pack(262143, -262144, 4096), 1'b1);
    collect("sat", 1);

    issue(-262144, 0, 0, -262144, 1'b1, pack(262143, 0, 0), 1'b1);
    collect("neg_extreme", 0);

    issue(12345, -777, 262143, 0, 1'b1, pack(0, 0, 0), 1'b0);
    collect("zero_scalar", 0);

    // Backpressure: new data offered while DONE must wait for the consume.
    issue(3000, 4000, -5000, 1536, 1'b1, pack(4500, 6000, -7500), 1'b0);
    repeat (3) @(negedge clk);
    chk("bp_valid", 64'(out_valid), 64'd1);
    held = out_vector;
    in_vector = pack(100, 200, 300);
    in_scalar = 19'd2048;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_vec", 64'(out_vector), 64'(held));
    end
    chk("bp_vec", 64'(out_vector), 64'(pack(4500, 6000, -7500)));
    void'(exp_q.pop_front());
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_consumed", 64'(out_valid), 64'd0);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    begin
      exp_t e;
      e.vec = pack(200, 400, 600);
      e.sat = 1'b0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_new_accepted", 64'(in_ready), 64'd0);
    collect("bp_new", 0);

    // Reset while in MUL_Y discards the operation.
    issue(50000, 60000, 70000, 3000, 1'b0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_vec", 64'(out_vector), 64'd0);
    chk("midrst_sat", 64'(out_sat), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_valid", 64'(seen), 64'd0);

    issue(-4096, 8192, 1, 1024, 1'b1, pack(-4096, 8192, 1), 1'b0);
    collect("after_rst", 0);

    xs = '{-123456, 262143, 77, -262144};
    ys = '{98765, -1, -54321, 262143};
    zs = '{5, 131072, 262000, -3};
    ss = '{1500, -1024, 2047, -700};
    for (int i = 0; i < 4; i++) begin
      if (i >= 2) begin
        xs[i] = int'($urandom_range(524287)) - 262144;
        ss[i] = int'($urandom_range(8191)) - 4096;
      end
      rx = ref_comp(xs[i], ss[i], sx);
      ry = ref_comp(ys[i], ss[i], sy);
      rz = ref_comp(zs[i], ss[i], sz);
      issue(xs[i], ys[i], zs[i], ss[i], 1'b1, pack(rx, ry, rz), sx | sy | sz);
      collect("model", 0);
    end

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
